derotate_demux: RTL and testbench
=================================

// Module: derotate_demux
// PURPOSE
//  Return path for the mux -> reg8 -> rotate datapath. Tracks the cumulative rotation applied
//  to a captured word and undoes it, rotating the received word back by the tracked offset.
//  The restored word is then steered into the A or B output register, selected by the
//  channel tag captured at load time. This recovers the original a/b operand from the
//  rotated 8-bit stream.
// PARAMETERS
//  WIDTH  8                  data word width in bits (>= 2)
//  OFS_W  $clog2(WIDTH)      width of rotation-offset counter
// PORTS
//  clk      in   1      rising-edge clock
//  rst      in   1      synchronous reset, active high
//  load     in   1      new word captured upstream; latch sel, clear offset
//  sel      in   1      channel tag sampled on load (0 = A, 1 = B)
//  step     in   1      upstream rotated one position this cycle
//  r_l      in   1      direction of step (1 = left, 0 = right)
//  req      in   1      restore din now and emit to the tagged channel
//  din      in   WIDTH  rotated word from upstream
//  a_out    out  WIDTH  last restored channel-A word (held)
//  b_out    out  WIDTH  last restored channel-B word (held)
//  a_valid  out  1      one-cycle pulse when a_out was updated
//  b_valid  out  1      one-cycle pulse when b_out was updated
//  err      out  1      one-cycle pulse when req arrives in IDLE
//  tracking out  1      high while in TRACK state
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE, offset=0, sel_tag=0, and every output is 0.
//    Reset mid-TRACK discards the offset with no emit.
//  - Rotate left by 1 = {x[WIDTH-2:0], x[WIDTH-1]}.
//    Offset counts net left steps, modulo WIDTH.
//  - FSM has two states:
//      IDLE --load--> TRACK
//      TRACK --load--> TRACK (re-arms: offset=0, new sel_tag)
//      Leaving TRACK is by rst only.
//  - In TRACK, a step with no load in the same cycle updates the offset:
//      r_l=1 -> offset+1; WIDTH-1 wraps to 0
//      r_l=0 -> offset-1; 0 wraps to WIDTH-1
//  - step in IDLE is ignored.
//  - req in TRACK with no load: on the same edge, the restored word is computed as
//    rotr(din, offset), using the offset value before any same-cycle step.
//      sel_tag=0 -> write a_out, a_valid=1 for the following cycle.
//      sel_tag=1 -> write b_out, b_valid=1 for the following cycle.
//    Latency is 1 clock, req -> valid. The offset is not cleared by req, so repeated
//    reqs reuse the tracked offset.
//  - A step in the same cycle as req is applied after the restore
//    (restore uses the old offset, the register takes the new one).
//  - load has priority over step and req in the same cycle:
//      offset=0, sel_tag=sel.
//      A concurrent req is dropped (no valid, no err).
//      A concurrent step is dropped.
//  - req in IDLE: no data update, err=1 for the following cycle.
//  - a_valid, b_valid and err are never high together.
//  - a_out and b_out hold their value until the next emit to the same channel or rst.
//  - Rotation uses a combinational barrel shift by offset. No arithmetic beyond the
//    modulo counter.
// TESTING (WIDTH=8)
//  1. rst, load sel=0, 3 steps r_l=1, req din=8'h8D -> next cycle a_out=8'hB1,
//     a_valid=1 for 1 cycle, b_out=0.
//  2. load sel=1, 1 step r_l=0 (offset 0->7), req din=8'h80 -> b_out=8'h01, b_valid pulse.
//  3. load sel=0, 9 steps r_l=1 (offset 1), req din=8'h03 -> a_out=8'h81. Proves wrap.
//  4. After reset, req din=8'hFF -> err=1 for 1 cycle; a_out=b_out=0, no valid.
//  5. In TRACK with offset 2, same cycle load sel=1 + step + req -> no valid, no err,
//     offset=0. Then req din=8'h5A -> b_out=8'h5A.
//  6. Offset 4, rst asserted mid-TRACK -> all outputs 0, tracking=0.
//     Then req -> err pulse.

Source files
------------

// File: rtl/derotate_demux_if.sv
// Bus between the rotate datapath return side and the de-rotating demux.
interface derotate_demux_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load;
  logic             sel;
  logic             step;
  logic             r_l;
  logic             req;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             a_valid;
  logic             b_valid;
  logic             err;
  logic             tracking;

  modport master (
    output load, sel, step, r_l, req, din,
    input  a_out, b_out, a_valid, b_valid, err, tracking
  );

  modport slave (
    input  load, sel, step, r_l, req, din,
    output a_out, b_out, a_valid, b_valid, err, tracking
  );
endinterface

// File: rtl/derotate_demux.sv
// Tracks net rotation applied upstream and undoes it, steering the restored word
// into the A or B output register selected by the tag captured at load.
module derotate_demux #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  derotate_demux_if.slave  bus
);

  localparam int unsigned OFS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [OFS_W-1:0] OFS_MAX = OFS_W'(WIDTH - 1);

  typedef enum logic {IDLE, TRACK} state_t;

  state_t             state_q, state_d;
  logic [OFS_W-1:0]   offset_q, offset_d;
  logic               sel_tag_q, sel_tag_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               a_valid_q, a_valid_d;
  logic               b_valid_q, b_valid_d;
  logic               err_q, err_d;
  logic [2*WIDTH-1:0] dbl_c;
  logic [WIDTH-1:0]   restored_c;

  // Barrel rotate-right of din by the current (pre-step) offset.
  always_comb begin
    dbl_c      = {bus.din, bus.din} >> offset_q;
    restored_c = dbl_c[WIDTH-1:0];
  end

  // Next-state, offset tracking and output steering; load outranks step and req.
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    sel_tag_d = sel_tag_q;
    a_d       = a_q;
    b_d       = b_q;
    a_valid_d = 1'b0;
    b_valid_d = 1'b0;
    err_d     = 1'b0;

    if (bus.load) begin
      state_d   = TRACK;
      offset_d  = '0;
      sel_tag_d = bus.sel;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req) err_d = 1'b1;
        end
        TRACK: begin
          if (bus.step) begin
            if (bus.r_l) offset_d = (offset_q == OFS_MAX) ? '0 : offset_q + OFS_W'(1);
            else         offset_d = (offset_q == '0) ? OFS_MAX : offset_q - OFS_W'(1);
          end
          if (bus.req) begin
            if (sel_tag_q) begin
              b_d       = restored_c;
              b_valid_d = 1'b1;
            end else begin
              a_d       = restored_c;
              a_valid_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      offset_q  <= '0;
      sel_tag_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      sel_tag_q <= sel_tag_d;
      a_q       <= a_d;
      b_q       <= b_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      err_q     <= err_d;
    end
  end

  assign bus.a_out    = a_q;
  assign bus.b_out    = b_q;
  assign bus.a_valid  = a_valid_q;
  assign bus.b_valid  = b_valid_q;
  assign bus.err      = err_q;
  assign bus.tracking = (state_q == TRACK);

endmodule

// File: tb/tb_derotate_demux.sv
// Directed bench for derotate_demux at WIDTH=8 with hand-computed expectations.
module tb_derotate_demux;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  derotate_demux_if #(.WIDTH(WIDTH)) bus ();

  derotate_demux #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs, then pulse inputs return low; sampled #1 after the edge.
  task automatic cyc(input logic ld, input logic s, input logic st, input logic rl,
                     input logic rq, input logic [WIDTH-1:0] d);
    bus.load = ld; bus.sel = s; bus.step = st; bus.r_l = rl; bus.req = rq; bus.din = d;
    @(posedge clk);
    #1;
    bus.load = 1'b0; bus.step = 1'b0; bus.req = 1'b0; bus.din = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic av, input logic bv, input logic e);
    check({tag, "_a_valid"}, 32'(bus.a_valid), 32'(av));
    check({tag, "_b_valid"}, 32'(bus.b_valid), 32'(bv));
    check({tag, "_err"},     32'(bus.err),     32'(e));
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.load = 1'b0; bus.sel = 1'b0; bus.step = 1'b0; bus.r_l = 1'b0;
    bus.req = 1'b0; bus.din = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_out", 32'(bus.a_out), 32'h0);
    check("rst_b_out", 32'(bus.b_out), 32'h0);
    check("rst_tracking", 32'(bus.tracking), 32'h0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // 1: offset 3, rotr(8D,3) = B1 on A
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t1_tracking", 32'(bus.tracking), 32'h1);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h8D);
    check("t1_a_out", 32'(bus.a_out), 32'hB1);
    check("t1_b_out", 32'(bus.b_out), 32'h0);
    check_flags("t1", 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_flags("t1_after", 1'b0, 1'b0, 1'b0);
    check("t1_a_hold", 32'(bus.a_out), 32'hB1);

    // 2: right step wraps 0 -> 7, rotr(80,7) = 01 on B
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80);
    check("t2_b_out", 32'(bus.b_out), 32'h01);
    check("t2_a_hold", 32'(bus.a_out), 32'hB1);
    check_flags("t2", 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_flags("t2_after", 1'b0, 1'b0, 1'b0);

    // 3: 9 left steps wrap to offset 1, rotr(03,1) = 81
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (9) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03);
    check("t3_a_out", 32'(bus.a_out), 32'h81);
    check_flags("t3", 1'b1, 1'b0, 1'b0);
    // req + step: restore with old offset 1, offset becomes 2
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h06);
    check("t3_req_step", 32'(bus.a_out), 32'h03);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03);
    check("t3_new_ofs", 32'(bus.a_out), 32'hC0);
    check("t3_b_hold", 32'(bus.b_out), 32'h01);

    // 4: req in IDLE after reset -> err only
    do_reset();
    check("t4_rst_a", 32'(bus.a_out), 32'h0);
    check("t4_rst_b", 32'(bus.b_out), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    check_flags("t4", 1'b0, 1'b0, 1'b1);
    check("t4_a_out", 32'(bus.a_out), 32'h0);
    check("t4_b_out", 32'(bus.b_out), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_flags("t4_after", 1'b0, 1'b0, 1'b0);
    // step in IDLE ignored, still not tracking
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    check("t4_idle_step", 32'(bus.tracking), 32'h0);

    // 5: load beats step and req; offset cleared, tag switched to B
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    check_flags("t5_load", 1'b0, 1'b0, 1'b0);
    check("t5_tracking", 32'(bus.tracking), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
    check("t5_b_out", 32'(bus.b_out), 32'h5A);
    check("t5_a_out", 32'(bus.a_out), 32'h0);
    check_flags("t5", 1'b0, 1'b1, 1'b0);

    // 6: reset mid-TRACK at offset 4, then req errors
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    do_reset();
    check("t6_a_out", 32'(bus.a_out), 32'h0);
    check("t6_b_out", 32'(bus.b_out), 32'h0);
    check("t6_tracking", 32'(bus.tracking), 32'h0);
    check_flags("t6_rst", 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
    check_flags("t6_req", 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
